// File: rtl/pcm_mm_scheduler_if.sv
// Request/response and PCM array bus for the PCM main-memory scheduler.
// The slave modport is the scheduler's view; master is the requester/array side.
interface pcm_mm_scheduler_if #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WB_DEPTH = 4
);
    logic                        schedule;
    logic                        cpu_write;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           cpu_in;
    logic                        resolved;
    logic [DATA_W-1:0]           data_out;
    logic [$clog2(WB_DEPTH):0]   wb_count;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  schedule, cpu_write, addr, cpu_in, mem_rdata,
        output resolved, data_out, wb_count, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output schedule, cpu_write, addr, cpu_in, mem_rdata,
        input  resolved, data_out, wb_count, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pcm_mm_scheduler.sv
// Memory-side responder for the PCM main-memory register block: serves CPU
// requests against the PCM array through a coalescing posted-write buffer.
module pcm_mm_scheduler #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 12,
    parameter int WB_DEPTH  = 4
) (
    input logic               clk,
    input logic               reset,
    pcm_mm_scheduler_if.slave bus
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0]    RD_LAST = 5'(READ_LAT);
    localparam logic [4:0]    WR_LAST = 5'(WRITE_LAT - 1);
    localparam logic [CW-1:0] FULL    = CW'(WB_DEPTH);

    typedef enum logic [2:0] {IDLE, RD_WAIT, DRAIN, WR_STALL, RESP, GAP} state_t;
    state_t state, next_state;

    logic [4:0]        cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] data_q;
    logic [WB_DEPTH-1:0] wb_valid;
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0]     head, tail, hit_idx;
    logic [CW-1:0]     count;
    logic              hit, full, accept, coalesce, rd_hit, rd_done, pop, push;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    // At most one valid entry can match, so the last match found is the only one.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (wb_valid[i] && wb_addr[i] == bus.addr) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign full      = (count == FULL);
    assign accept    = (state == IDLE) && bus.schedule;
    assign coalesce  = accept && bus.cpu_write && hit;
    assign rd_hit    = accept && !bus.cpu_write && hit;
    assign rd_done   = (state == RD_WAIT) && (cnt == RD_LAST);
    assign pop       = ((state == DRAIN) || (state == WR_STALL)) && (cnt == 5'd0);
    assign push      = (accept && bus.cpu_write && !hit && !full) ||
                       ((state == WR_STALL) && (cnt == WR_LAST));
    assign push_addr = (state == WR_STALL) ? req_addr : bus.addr;
    assign push_data = (state == WR_STALL) ? req_data : bus.cpu_in;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.schedule) begin
                    if (bus.cpu_write) next_state = (hit || !full) ? RESP : WR_STALL;
                    else               next_state = hit ? RESP : RD_WAIT;
                end else if (count != '0) begin
                    next_state = DRAIN;
                end
            end
            RD_WAIT:  if (cnt == RD_LAST) next_state = RESP;
            DRAIN:    if (cnt == WR_LAST) next_state = IDLE;
            WR_STALL: if (cnt == WR_LAST) next_state = RESP;
            RESP:     next_state = GAP;
            GAP:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Drains stay in DRAIN for the whole array busy time, so IDLE always means the array is free.
    always_comb begin
        bus.resolved  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            RD_WAIT: begin
                if (cnt == 5'd0) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = req_addr;
                end
            end
            DRAIN, WR_STALL: begin
                if (cnt == 5'd0) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = wb_addr[head];
                    bus.mem_wdata = wb_data[head];
                end
            end
            RESP:    bus.resolved = 1'b1;
            default: ;
        endcase
    end

    // When a stall drain and its refill land together, the refill must win the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            req_addr <= '0;
            req_data <= '0;
            data_q   <= '0;
            wb_valid <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            cnt <= (next_state != state) ? 5'd0 : cnt + 5'd1;
            if (accept) begin
                req_addr <= bus.addr;
                req_data <= bus.cpu_in;
            end
            if (rd_hit)       data_q <= wb_data[hit_idx];
            else if (rd_done) data_q <= bus.mem_rdata;
            if (coalesce) wb_data[hit_idx] <= bus.cpu_in;
            if (pop) begin
                wb_valid[head] <= 1'b0;
                head           <= head + PW'(1);
            end
            if (push) begin
                wb_valid[tail] <= 1'b1;
                wb_addr[tail]  <= push_addr;
                wb_data[tail]  <= push_data;
                tail           <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign bus.data_out = data_q;
    assign bus.wb_count = count;
endmodule

// File: tb/tb_pcm_mm_scheduler.sv
// Scoreboard bench for pcm_mm_scheduler: a PCM array model, a latest-value memory
// reference and an allocation-ordered buffer model check reads, drains and counts.
module tb_pcm_mm_scheduler;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 12;
    localparam int WB_DEPTH  = 4;
    localparam int WAIT_MAX  = 300;

    typedef struct { bit is_write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_q[$];
    ent_t model_q[$];
    logic [DATA_W-1:0] arr[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] rd_due[int];

    int resolved_cnt = 0, last_res_cyc = 0, rd_cmds = 0, wr_cmds = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0, last_cmd_cyc = -1000, last_cmd_lat = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0;
    exp_t mon_e;
    int   mon_idx;
    bit   mon_hit;

    pcm_mm_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) bus ();

    pcm_mm_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
        .WRITE_LAT(WRITE_LAT), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * 20'd7) ^ 16'hC3A5;
    endfunction

    function automatic logic [DATA_W-1:0] arrayValue(input logic [ADDR_W-1:0] a);
        return arr.exists(a) ? arr[a] : dflt(a);
    endfunction

    function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : arrayValue(a);
    endfunction

    // Array read data is valid only in the one cycle READ_LAT after the command.
    always @(posedge clk) begin
        #1;
        if (rd_due.exists(cyc)) begin
            bus.mem_rdata = rd_due[cyc];
            rd_due.delete(cyc);
        end else begin
            bus.mem_rdata = DATA_W'($urandom);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            exp_q.delete();
            rd_due.delete();
            last_cmd_cyc = -1000;
        end else begin
            if (bus.mem_en) begin
                checkOutput("cmd_spacing", 32'((cyc - last_cmd_cyc) >= last_cmd_lat), 32'd1);
                last_cmd_cyc = cyc;
                last_cmd_lat = bus.mem_we ? WRITE_LAT : READ_LAT;
                if (bus.mem_we) begin
                    wr_cmds++;
                    last_wr_cyc  = cyc;
                    last_wr_addr = bus.mem_addr;
                    last_wr_data = bus.mem_wdata;
                    arr[bus.mem_addr] = bus.mem_wdata;
                    checkOutput("drain_pending", 32'(model_q.size() > 0), 32'd1);
                    if (model_q.size() > 0) begin
                        checkOutput("drain_addr", 32'(bus.mem_addr), 32'(model_q[0].addr));
                        checkOutput("drain_data", 32'(bus.mem_wdata), 32'(model_q[0].data));
                        void'(model_q.pop_front());
                    end
                end else begin
                    rd_cmds++;
                    last_rd_cyc = cyc;
                    rd_due[cyc + READ_LAT] = arrayValue(bus.mem_addr);
                    mon_hit = 1'b0;
                    foreach (model_q[i]) if (model_q[i].addr == bus.mem_addr) mon_hit = 1'b1;
                    checkOutput("read_not_buffered", 32'(!mon_hit), 32'd1);
                end
            end
            if (bus.resolved) begin
                resolved_cnt++;
                last_res_cyc = cyc;
                checkOutput("resolved_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_write) begin
                        checkOutput("read_data", 32'(bus.data_out), 32'(mon_e.data));
                    end else begin
                        mon_idx = -1;
                        foreach (model_q[i]) if (model_q[i].addr == mon_e.addr) mon_idx = i;
                        if (mon_idx >= 0) model_q[mon_idx].data = mon_e.data;
                        else model_q.push_back('{addr: mon_e.addr, data: mon_e.data});
                        checkOutput("wb_bound", 32'(model_q.size() <= WB_DEPTH), 32'd1);
                        checkOutput("wb_count", 32'(bus.wb_count), 32'(model_q.size()));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.schedule = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                 output int t_issue, output int lat);
        exp_t e;
        int   n0, waited;
        e.is_write = w;
        e.addr     = a;
        e.data     = w ? d : expRead(a);
        if (w) ref_mem[a] = d;
        exp_q.push_back(e);
        bus.schedule  = 1'b1;
        bus.cpu_write = w;
        bus.addr      = a;
        bus.cpu_in    = d;
        t_issue = cyc;
        n0      = resolved_cnt;
        waited  = 0;
        while (resolved_cnt == n0 && waited < WAIT_MAX) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("resolve_in_time", 32'(waited < WAIT_MAX), 32'd1);
        lat = last_res_cyc - t_issue;
        #1;
        bus.schedule = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, lat, r0, w0, n0;
        bit w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        bus.schedule = 1'b0; bus.cpu_write = 1'b0; bus.addr = '0; bus.cpu_in = '0;
        arr[20'h00010] = 16'hBEEF;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resolved", 32'(bus.resolved), 32'd0);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("rst_wb_count", 32'(bus.wb_count), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_mem = arr;

        // Read miss on an empty buffer.
        applyStimulus(1'b0, 20'h00010, 16'h0, t, lat);
        checkOutput("miss_mem_en_cycle", 32'(last_rd_cyc - t), 32'd1);
        checkOutput("miss_latency", 32'(lat), 32'(READ_LAT + 2));
        checkOutput("miss_data", 32'(bus.data_out), 32'hBEEF);

        // Posted write then read hit, no array read.
        r0 = rd_cmds;
        applyStimulus(1'b1, 20'h00020, 16'h1234, t, lat);
        checkOutput("write_latency", 32'(lat), 32'd1);
        applyStimulus(1'b0, 20'h00020, 16'h0, t, lat);
        checkOutput("hit_latency", 32'(lat), 32'd1);
        checkOutput("hit_data", 32'(bus.data_out), 32'h1234);
        checkOutput("hit_no_array_read", 32'(rd_cmds), 32'(r0));

        // Coalescing writes produce a single drain of the newest data.
        idle(30);
        w0 = wr_cmds;
        applyStimulus(1'b1, 20'h00030, 16'hAAAA, t, lat);
        applyStimulus(1'b1, 20'h00030, 16'h5555, t, lat);
        checkOutput("coalesce_count", 32'(bus.wb_count), 32'd1);
        idle(30);
        checkOutput("coalesce_one_drain", 32'(wr_cmds), 32'(w0 + 1));
        checkOutput("coalesce_drain_addr", 32'(last_wr_addr), 32'h00030);
        checkOutput("coalesce_drain_data", 32'(last_wr_data), 32'h5555);

        // Fifth distinct write stalls behind a drain of the oldest entry.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 20'h00100 + 20'(k), 16'(16'h1000 + k), t, lat);
            if (k < 4) checkOutput("fill_latency", 32'(lat), 32'd1);
        end
        checkOutput("stall_latency_min", 32'(lat >= WRITE_LAT + 1), 32'd1);
        checkOutput("stall_latency_max", 32'(lat <= WRITE_LAT + 3), 32'd1);
        checkOutput("stall_drained_oldest", 32'(last_wr_addr), 32'h00100);
        checkOutput("stall_final_count", 32'(bus.wb_count), 32'd4);

        // Read miss arriving just after a drain starts waits for the array.
        idle(1);
        applyStimulus(1'b0, 20'h00555, 16'h0, t, lat);
        checkOutput("drain_next_addr", 32'(last_wr_addr), 32'h00101);
        checkOutput("read_after_drain_gap", 32'((last_rd_cyc - last_wr_cyc) >= WRITE_LAT), 32'd1);
        checkOutput("read_after_drain_data", 32'(bus.data_out), 32'(dflt(20'h00555)));

        // Reset in the middle of a read miss aborts it.
        bus.schedule = 1'b1; bus.cpu_write = 1'b0; bus.addr = 20'h00666;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        bus.schedule = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_mem = arr;
        n0 = resolved_cnt;
        @(negedge clk);
        checkOutput("abort_resolved", 32'(bus.resolved), 32'd0);
        checkOutput("abort_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("abort_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("abort_wb_count", 32'(bus.wb_count), 32'd0);
        @(posedge clk);
        #1;
        idle(10);
        checkOutput("abort_no_resolved", 32'(resolved_cnt), 32'(n0));

        // Random traffic over a small address pool to exercise hits, coalescing and stalls.
        for (int k = 0; k < 200; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 20'h02000 + 20'($urandom_range(0, 7));
            d = DATA_W'($urandom);
            applyStimulus(w, a, d, t, lat);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
        end

        idle(WB_DEPTH * (WRITE_LAT + 2) + 20);
        checkOutput("final_wb_count", 32'(bus.wb_count), 32'd0);
        checkOutput("final_model_empty", 32'(model_q.size()), 32'd0);
        checkOutput("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
